// File: rtl/wb_expect_checker_if.sv
// Load, start and register-file writeback tap bundle for wb_expect_checker,
// together with the checker's status outputs.
interface wb_expect_checker_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned DEPTH  = 16
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic              clear;
  logic              load_valid;
  logic [REG_W-1:0]  load_reg;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              start;
  logic              reg_write;
  logic [REG_W-1:0]  write_reg;
  logic [DATA_W-1:0] write_data;
  logic              armed;
  logic              done;
  logic              pass;
  logic              fail;
  logic [1:0]        fail_code;
  logic [IDX_W-1:0]  fail_index;
  logic [REG_W-1:0]  got_reg;
  logic [DATA_W-1:0] got_data;
  logic [CNT_W-1:0]  match_count;

  modport master (
    output clear, load_valid, load_reg, load_data, start,
           reg_write, write_reg, write_data,
    input  load_ready, armed, done, pass, fail, fail_code, fail_index,
           got_reg, got_data, match_count
  );

  modport slave (
    input  clear, load_valid, load_reg, load_data, start,
           reg_write, write_reg, write_data,
    output load_ready, armed, done, pass, fail, fail_code, fail_index,
           got_reg, got_data, match_count
  );
endinterface

// File: rtl/wb_expect_checker.sv
// Ordered register-file writeback checker: compares observed writes against a
// loaded table of expected (reg, data) pairs. Timeout enabled by WB_CHECK_TIMEOUT_EN.
module wb_expect_checker #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 1024,
  parameter bit          STRICT  = 1'b1
) (
  input logic              clk,
  input logic              rst,
  wb_expect_checker_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("wb_expect_checker: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_PASS, S_FAIL} state_t;

  typedef struct packed {
    logic [REG_W-1:0]  rg;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  match_count;
  logic [1:0]        fail_code;
  logic [IDX_W-1:0]  fail_index;
  logic [REG_W-1:0]  got_reg;
  logic [DATA_W-1:0] got_data;
  entry_t            table_q [DEPTH];

`ifdef WB_CHECK_TIMEOUT_EN
  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TMR_W-1:0] timer;
`endif

  logic   load_acc_c;
  logic   live_c;
  logic   hit_c;
  logic   last_c;
  entry_t cur_c;

  assign load_acc_c = (state == S_IDLE) && !bus.clear && bus.load_valid &&
                      (count < CNT_W'(DEPTH));
  assign cur_c      = table_q[match_count[IDX_W-1:0]];
  // x0 writes never take part in checking
  assign live_c     = bus.reg_write && (bus.write_reg != '0);
  assign hit_c      = live_c && (bus.write_reg == cur_c.rg) && (bus.write_data == cur_c.data);
  assign last_c     = (match_count == count - CNT_W'(1));

  // Table storage needs no reset; count qualifies which entries are meaningful
  always_ff @(posedge clk) begin
    if (load_acc_c) begin
      table_q[count[IDX_W-1:0]] <= entry_t'{rg: bus.load_reg, data: bus.load_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      state       <= S_IDLE;
      count       <= '0;
      match_count <= '0;
      fail_code   <= 2'd0;
      fail_index  <= '0;
      got_reg     <= '0;
      got_data    <= '0;
`ifdef WB_CHECK_TIMEOUT_EN
      timer       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (load_acc_c) count <= count + CNT_W'(1);
          if (bus.start) begin
            match_count <= '0;
`ifdef WB_CHECK_TIMEOUT_EN
            timer       <= '0;
`endif
            // a load accepted alongside start joins the armed sequence
            state <= ((count == '0) && !load_acc_c) ? S_PASS : S_ARMED;
          end
        end
        S_ARMED: begin
          if (hit_c) begin
            match_count <= match_count + CNT_W'(1);
`ifdef WB_CHECK_TIMEOUT_EN
            timer       <= '0;
`endif
            if (last_c) state <= S_PASS;
          end else if (live_c && STRICT) begin
            state      <= S_FAIL;
            fail_code  <= 2'd1;
            fail_index <= match_count[IDX_W-1:0];
            got_reg    <= bus.write_reg;
            got_data   <= bus.write_data;
          end
`ifdef WB_CHECK_TIMEOUT_EN
          else if (timer == TMR_W'(TIMEOUT - 1)) begin
            state      <= S_FAIL;
            fail_code  <= 2'd2;
            fail_index <= match_count[IDX_W-1:0];
          end else begin
            timer <= timer + TMR_W'(1);
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.load_ready  = (state == S_IDLE) && (count < CNT_W'(DEPTH));
  assign bus.armed       = (state == S_ARMED);
  assign bus.done        = (state == S_PASS) || (state == S_FAIL);
  assign bus.pass        = (state == S_PASS);
  assign bus.fail        = (state == S_FAIL);
  assign bus.fail_code   = fail_code;
  assign bus.fail_index  = fail_index;
  assign bus.got_reg     = got_reg;
  assign bus.got_data    = got_data;
  assign bus.match_count = match_count;
endmodule

// File: tb/tb_wb_expect_checker.sv
// Bench for wb_expect_checker: a strict and a lenient instance share stimulus and
// are checked every cycle against a queue-based reference model.
module tb_wb_expect_checker;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_expect_checker_if #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH)) s_if ();
  wb_expect_checker_if #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH)) l_if ();

  wb_expect_checker #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH),
                      .TIMEOUT(TIMEOUT), .STRICT(1'b1))
    dut_s (.clk(clk), .rst(rst), .bus(s_if));
  wb_expect_checker #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH),
                      .TIMEOUT(TIMEOUT), .STRICT(1'b0))
    dut_l (.clk(clk), .rst(rst), .bus(l_if));

  int errors = 0;
  int checks = 0;

  // scenario description
  logic [4:0]  ld_r [$];
  logic [31:0] ld_d [$];
  bit          w_v  [$];
  logic [4:0]  w_r  [$];
  logic [31:0] w_d  [$];
  logic [4:0]  exp_r [$];
  logic [31:0] exp_d [$];

  // model state: index 0 strict, 1 lenient
  int          m_pos   [2];
  int          m_since [2];
  bit          m_done  [2];
  bit          m_pass  [2];
  logic [1:0]  m_code  [2];
  int          m_fidx  [2];
  logic [4:0]  m_greg  [2];
  logic [31:0] m_gdata [2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic clr, input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                     input logic st, input logic rw, input logic [4:0] wr, input logic [31:0] wd);
    s_if.clear = clr; s_if.load_valid = lv; s_if.load_reg = lr; s_if.load_data = ld;
    s_if.start = st;  s_if.reg_write = rw;  s_if.write_reg = wr; s_if.write_data = wd;
    l_if.clear = clr; l_if.load_valid = lv; l_if.load_reg = lr; l_if.load_data = ld;
    l_if.start = st;  l_if.reg_write = rw;  l_if.write_reg = wr; l_if.write_data = wd;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  function automatic logic [63:0] status_of(input int d);
    if (d == 0)
      return 64'({s_if.load_ready, s_if.armed, s_if.done, s_if.pass, s_if.fail,
                  s_if.fail_code, s_if.fail_index, s_if.match_count});
    return 64'({l_if.load_ready, l_if.armed, l_if.done, l_if.pass, l_if.fail,
                l_if.fail_code, l_if.fail_index, l_if.match_count});
  endfunction

  function automatic logic [63:0] capture_of(input int d);
    if (d == 0) return 64'({s_if.got_reg, s_if.got_data});
    return 64'({l_if.got_reg, l_if.got_data});
  endfunction

  function automatic string dname(input int d);
    return (d == 0) ? "strict" : "lenient";
  endfunction

  task automatic check_idle(input string tag, input bit lr);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s/%s/status", tag, dname(d)), status_of(d), 64'({lr, 11'b0}));
      chk($sformatf("%s/%s/capture", tag, dname(d)), capture_of(d), 64'd0);
    end
  endtask

  task automatic check_model(input string tag);
    logic fl;
    for (int d = 0; d < 2; d++) begin
      fl = m_done[d] && !m_pass[d];
      chk($sformatf("%s/%s/status", tag, dname(d)), status_of(d),
          64'({1'b0, !m_done[d], m_done[d], m_pass[d], fl, m_code[d], 2'(m_fidx[d]), 3'(m_pos[d])}));
      chk($sformatf("%s/%s/capture", tag, dname(d)), capture_of(d), 64'({m_greg[d], m_gdata[d]}));
    end
  endtask

  function automatic void mdl_arm();
    for (int d = 0; d < 2; d++) begin
      m_pos[d] = 0; m_since[d] = 0; m_code[d] = 2'd0; m_fidx[d] = 0;
      m_greg[d] = '0; m_gdata[d] = '0;
      m_done[d] = (exp_r.size() == 0);
      m_pass[d] = (exp_r.size() == 0);
    end
  endfunction

  function automatic void mdl_step(input bit v, input logic [4:0] r, input logic [31:0] x);
    for (int d = 0; d < 2; d++) begin
      if (m_done[d]) continue;
      if (v && r != 5'd0 && r == exp_r[m_pos[d]] && x == exp_d[m_pos[d]]) begin
        m_pos[d]++;
        m_since[d] = 0;
        if (m_pos[d] == exp_r.size()) begin
          m_done[d] = 1'b1; m_pass[d] = 1'b1;
        end
      end else if (v && r != 5'd0 && d == 0) begin
        m_done[d] = 1'b1; m_code[d] = 2'd1; m_fidx[d] = m_pos[d];
        m_greg[d] = r; m_gdata[d] = x;
      end else begin
        m_since[d]++;
`ifdef WB_CHECK_TIMEOUT_EN
        if (m_since[d] == TIMEOUT) begin
          m_done[d] = 1'b1; m_code[d] = 2'd2; m_fidx[d] = m_pos[d];
        end
`endif
      end
    end
  endfunction

  function automatic void scn_reset();
    ld_r.delete(); ld_d.delete(); w_v.delete(); w_r.delete(); w_d.delete();
  endfunction

  function automatic void pl(input logic [4:0] r, input logic [31:0] x);
    ld_r.push_back(r); ld_d.push_back(x);
  endfunction

  function automatic void pw(input bit v, input logic [4:0] r, input logic [31:0] x);
    w_v.push_back(v); w_r.push_back(r); w_d.push_back(x);
  endfunction

  task automatic load_all(input string name, input bit with_start);
    int last;
    last = ld_r.size() - 1;
    exp_r.delete(); exp_d.delete();
    for (int i = 0; i < ld_r.size(); i++) begin
      chk($sformatf("%s/load_ready%0d/strict", name, i), 64'(s_if.load_ready), 64'(i < DEPTH));
      chk($sformatf("%s/load_ready%0d/lenient", name, i), 64'(l_if.load_ready), 64'(i < DEPTH));
      drv(1'b0, 1'b1, ld_r[i], ld_d[i], with_start && (i == last), 1'b0, 5'd0, 32'd0);
      tick();
      if (i < DEPTH) begin
        exp_r.push_back(ld_r[i]); exp_d.push_back(ld_d[i]);
      end
    end
    drv(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic run_scn(input string name, input bit same_cycle);
    drv(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    drv(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    check_idle({name, "/cleared"}, 1'b1);
    load_all(name, same_cycle && ld_r.size() > 0);
    if (!(same_cycle && ld_r.size() > 0)) begin
      drv(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
      tick();
      drv(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    end
    mdl_arm();
    check_model({name, "/armed"});
    for (int k = 0; k < w_v.size(); k++) begin
      drv(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, w_v[k], w_r[k], w_d[k]);
      tick();
      mdl_step(w_v[k], w_r[k], w_d[k]);
      check_model($sformatf("%s/c%0d", name, k + 1));
    end
    drv(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    drv(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check_idle("reset", 1'b1);

    // single entry after idle cycles
    scn_reset(); pl(5'd2, 32'hE);
    pw(0, 0, 0); pw(0, 0, 0); pw(0, 0, 0); pw(1, 5'd2, 32'hE); pw(0, 0, 0);
    run_scn("single", 1'b0);

    // ordered three writes with an interleaved x0 write
    scn_reset(); pl(5'd1, 32'h5); pl(5'd2, 32'hE); pl(5'd3, 32'hF);
    pw(1, 5'd1, 32'h5); pw(1, 5'd0, 32'h7); pw(1, 5'd2, 32'hE); pw(1, 5'd3, 32'hF); pw(0, 0, 0);
    run_scn("ordered", 1'b0);

    // wrong data then right data
    scn_reset(); pl(5'd2, 32'hE);
    pw(1, 5'd2, 32'hF); pw(1, 5'd2, 32'hE); pw(0, 0, 0);
    run_scn("mismatch", 1'b0);

    // no writes at all: timeout or indefinite wait
    scn_reset(); pl(5'd4, 32'h1);
    for (int k = 0; k < 100; k++) pw(0, 0, 0);
    run_scn("timeout", 1'b0);

    // load issued in the start cycle
    scn_reset(); pl(5'd7, 32'hA5); pl(5'd9, 32'h5A);
    pw(1, 5'd7, 32'hA5); pw(1, 5'd9, 32'h5A); pw(0, 0, 0);
    run_scn("load_with_start", 1'b1);

    // overfill the table, then start and clear together
    scn_reset();
    for (int i = 0; i <= DEPTH; i++) pl(5'(i + 1), 32'(i * 16 + 3));
    drv(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    load_all("overfill", 1'b0);
    chk("overfill/full/strict", 64'(s_if.load_ready), 64'd0);
    chk("overfill/full/lenient", 64'(l_if.load_ready), 64'd0);
    drv(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
    tick();
    drv(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    check_idle("start_clear", 1'b1);

    // full table passes on DEPTH matches; the dropped extra entry is not expected
    for (int i = 0; i < DEPTH; i++) pw(1, 5'(i + 1), 32'(i * 16 + 3));
    pw(0, 0, 0);
    run_scn("full_table", 1'b0);

    // empty table passes immediately
    scn_reset(); pw(0, 0, 0);
    run_scn("empty", 1'b0);

    // reset while mid-sequence
    scn_reset(); pl(5'd1, 32'h11); pl(5'd2, 32'h22); pl(5'd3, 32'h33);
    pw(1, 5'd1, 32'h11); pw(0, 0, 0);
    run_scn("mid_reset", 1'b0);
    rst = 1'b1;
    tick();
    check_idle("mid_reset/after_rst", 1'b1);
    rst = 1'b0;

    // randomized sequences with noise writes
    for (int t = 0; t < 8; t++) begin
      int n;
      scn_reset();
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) pl(5'($urandom_range(1, 31)), $urandom);
      for (int i = 0; i < n; i++) begin
        int noise;
        noise = $urandom_range(0, 3);
        for (int j = 0; j < noise; j++) begin
          case ($urandom_range(0, 2))
            0:       pw(0, 5'd0, 32'd0);
            1:       pw(1, 5'd0, $urandom);
            default: pw(1, 5'($urandom_range(1, 31)), $urandom);
          endcase
        end
        pw(1, ld_r[i], ld_d[i]);
      end
      pw(0, 0, 0); pw(0, 0, 0);
      run_scn($sformatf("rand%0d", t), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_expect_checker.md
# wb_expect_checker

Parametrised register-file writeback checker for the CPU bench and on-board self-test. Holds a table of up to DEPTH expected (register, data) writes, watches the register-file write port (`reg_write`, `write_reg`, `write_data`) and reports pass/fail with the failing index and captured values. It generalises single-write directed instruction checks to ordered multi-write sequences with a timeout. It sits beside `rf` inside `cpu_uart_top` or in the bench, tapping the same writeback signals.

## Interface
- DATA_W, 32, writeback data width
- REG_W, 5, register index width
- DEPTH, 16, max expected writes (power of two, >=2)
- TIMEOUT, 1024, max cycles between consecutive matches while armed (>=1)
- STRICT, 1, 1: any unmatched non-x0 write fails; 0: unmatched writes ignored
- clk  in  1  clock; one clock domain
- rst  in  1  synchronous, active-high reset
- clear  in  1  return to IDLE and empty the table (synchronous)
- load_valid  in  1  expected entry present
- load_reg  in  REG_W  expected destination register
- load_data  in  DATA_W  expected write data
- load_ready  out  1  entry accepted this cycle when high with load_valid
- start  in  1  arm the checker (IDLE only)
- reg_write  in  1  register-file write enable (tap)
- write_reg  in  REG_W  register-file write index (tap)
- write_data  in  DATA_W  register-file write data (tap)
- armed  out  1  checker monitoring
- done  out  1  PASS or FAIL reached (sticky)
- pass  out  1  all entries matched in order (sticky)
- fail  out  1  failure (sticky)
- fail_code  out  2  0 none, 1 mismatch, 2 timeout
- fail_index  out  $clog2(DEPTH)  entry index at failure
- got_reg / got_data  out  REG_W / DATA_W  offending write captured (zero on timeout)
- match_count  out  $clog2(DEPTH)+1  entries matched so far

## Operation
- States: IDLE, ARMED, PASS, FAIL. Reset: IDLE, table count 0; all outputs 0 except load_ready=1.
- IDLE: load_ready = (count < DEPTH). load_valid && load_ready writes entry[count], count++. Full table: load_ready=0, loads dropped.
- start in IDLE: count==0 -> PASS; else -> ARMED, idx=0, timer=0. start outside IDLE ignored.
- load and start same cycle: entry accepted and included in the armed sequence.
- ARMED, reg_write high: write_reg==0 always ignored (x0 writes). Match (write_reg==entry[idx].reg && write_data==entry[idx].data): idx++, timer=0; if idx was count-1 -> PASS. Non-match: STRICT=1 -> FAIL code 1, capture index/reg/data; STRICT=0 -> ignored.
- Timer counts every ARMED cycle without a match; timer reaching TIMEOUT-1 without match -> FAIL code 2 (see Configuration).
- PASS/FAIL hold until clear or rst. clear from any state -> IDLE, count=0, status cleared; table contents need not be zeroed.
- clear and start same cycle: clear wins. rst mid-sequence: IDLE, count 0, all status cleared.

## Timing
- Load: entry stored at the accepting clk edge; usable by a start in the next cycle or the same cycle.
- start at edge n -> armed=1 after n; first observed write is sampled at edge n+1 (a write coincident with start is not checked).
- Write matched/mismatched at edge m -> pass/fail/done, fail_code, captures valid after edge m (registered, 1-cycle latency from write cycle).
- match_count updates at the same edge as the match.
- Timeout: with no match, fail asserts after exactly TIMEOUT armed cycles after the last match or arming.

## Configuration
- WB_CHECK_TIMEOUT_EN defined: timer and fail_code 2 present as above.
- Undefined: no timer logic; ARMED waits indefinitely; fail_code never 2.

## Test plan
- Reset, load {r2,0xE}, start, 3 idle cycles, write r2=0xE -> pass=1, done=1, match_count=1 one cycle after write.
- Load {r1,0x5},{r2,0xE},{r3,0xF}; drive r1=0x5, x0=0x7, r2=0xE, r3=0xF -> pass; x0 write ignored.
- STRICT=1, load {r2,0xE}; drive r2=0xF -> fail=1, fail_code=1, fail_index=0, got_reg=2, got_data=0xF. STRICT=0: same write ignored, then r2=0xE -> pass.
- WB_CHECK_TIMEOUT_EN, TIMEOUT=8, load one entry, start, no writes -> fail_code=2 exactly 8 cycles after arming; without macro, no fail after 100 cycles.
- Load DEPTH+1 entries -> load_ready low on last, count=DEPTH; start then clear same cycle -> IDLE, match_count=0.
- Start with empty table -> pass next cycle; rst asserted while ARMED mid-sequence -> all outputs at reset values next cycle.
